// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One outstanding CPU request; refills on read miss, writes through on every store.
module cache_ctrl #(
  parameter int CACHE_SIZE = 16,
  localparam int IDX_W = $clog2(CACHE_SIZE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        op_type,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_REQ, S_RD_WAIT, S_RESP, S_WR_REQ
  } state_t;

  state_t                  state_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic                    op_q;
  logic [CACHE_SIZE-1:0]   valid_q;
  logic [TAG_W-1:0]        tag_mem [CACHE_SIZE];
  logic [31:0]             data_mem [CACHE_SIZE];
  logic                    resp_valid_q;
  logic [31:0]             resp_rdata_q;
  logic                    mem_req_valid_q;
  logic [31:0]             mem_addr_q;
  logic                    mem_we_q;
  logic [31:0]             mem_wdata_q;
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    lkp_hit;
  logic                    unused_addr_bits;

  assign idx              = addr_q[IDX_W+1:2];
  assign tag              = addr_q[31:IDX_W+2];
  assign lkp_hit          = valid_q[idx] && (tag_mem[idx] == tag);
  assign unused_addr_bits = ^addr_q[1:0];

  // Flush takes the IDLE cycle, so a simultaneous request is not accepted.
  assign req_ready     = (state_q == S_IDLE) && !flush && !rst;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      op_q            <= 1'b0;
      valid_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            op_q    <= op_type;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lkp_hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
          end
          if (op_q) begin
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= 1'b1;
            mem_addr_q      <= {addr_q[31:2], 2'b00};
            mem_wdata_q     <= wdata_q;
            state_q         <= S_WR_REQ;
          end else if (lkp_hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= data_mem[idx];
            state_q      <= S_IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= {addr_q[31:2], 2'b00};
            state_q         <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx] <= 1'b1;
            resp_rdata_q <= mem_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b1;
            state_q         <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP && op_q && lkp_hit) begin
      data_mem[idx] <= wdata_q;
    end
    if (state_q == S_RD_WAIT && mem_resp_valid) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: scoreboard of expected responses, a monitor
// that checks each resp_valid pulse, and a behavioural memory responder.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        op_type = 1'b0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  cache_ctrl #(.CACHE_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .op_type(op_type), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;
  mreq_t mem_log[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_read) chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Memory model: accepts after acc_dly wait cycles, returns reads ret_dly cycles later.
  logic [31:0] memarr [logic [31:0]];
  int          acc_dly = 0;
  int          ret_dly = 0;
  int          wcnt = 0;
  int          rcnt = 0;
  bit          pend_rd = 1'b0;
  logic [31:0] rd_data = '0;
  mreq_t       cap;

  always @(negedge clk) begin
    mreq_t r;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (pend_rd) begin
      if (rcnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = rd_data;
        pend_rd        = 1'b0;
      end else begin
        rcnt--;
      end
    end
    if (rst) begin
      wcnt = 0;
    end else if (mem_req_valid) begin
      if (wcnt == 0) begin
        cap.we = mem_we; cap.addr = mem_addr; cap.wdata = mem_wdata;
      end else begin
        chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cap.we});
        chk("mem_addr_stable", mem_addr, cap.addr);
        if (cap.we) chk("mem_wdata_stable", mem_wdata, cap.wdata);
      end
      if (wcnt >= acc_dly) begin
        mem_req_ready = 1'b1;
        r.we = mem_we; r.addr = mem_addr; r.wdata = mem_wdata;
        mem_log.push_back(r);
        if (mem_we) begin
          memarr[mem_addr] = mem_wdata;
        end else begin
          pend_rd = 1'b1;
          rcnt    = ret_dly;
          rd_data = memarr.exists(mem_addr) ? memarr[mem_addr] : 32'h0;
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit expect_resp, input logic [31:0] exp_rd, input int exp_lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; op_type = op; req_addr = addr; req_wdata = wdata;
    if (expect_resp) begin
      e.is_read = (op == 1'b0); e.rdata = exp_rd; e.acc = cyc + 1; e.lat = exp_lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #1;
    while (!(sb.size() == 0 && req_ready) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_log(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    mreq_t r;
    if (mem_log.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no memory request expected addr %h", name, addr);
    end else begin
      r = mem_log.pop_front();
      chk({name, "_we"}, {31'd0, r.we}, {31'd0, we});
      chk({name, "_addr"}, r.addr, addr);
      if (we) chk({name, "_wdata"}, r.wdata, wdata);
    end
  endtask

  task automatic chk_cnt(input logic [31:0] h, input logic [31:0] m);
    chk("hit_count", hit_count, h);
    chk("miss_count", miss_count, m);
  endtask

  initial begin
    memarr[32'h40]  = 32'hDEAD_BEEF;
    memarr[32'h100] = 32'h0BAD_F00D;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk_cnt(32'd0, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // cold read miss, memory returns two cycles late
    acc_dly = 0; ret_dly = 2;
    issue(1'b0, 32'h40, '0, 1'b1, 32'hDEAD_BEEF, 5);
    wait_idle();
    chk_log("miss40", 1'b0, 32'h40, '0);
    chk_cnt(32'd0, 32'd1);

    // read hit: one-cycle latency, no memory traffic
    issue(1'b0, 32'h40, '0, 1'b1, 32'hDEAD_BEEF, 1);
    wait_idle();
    chk("hit_no_memreq", 32'(mem_log.size()), 32'd0);
    chk_cnt(32'd1, 32'd1);

    // write hit with a three-cycle accept stall
    acc_dly = 3;
    issue(1'b1, 32'h40, 32'h1234_5678, 1'b1, '0, 5);
    wait_idle();
    chk_log("wr40", 1'b1, 32'h40, 32'h1234_5678);
    chk_cnt(32'd2, 32'd1);
    acc_dly = 0;
    issue(1'b0, 32'h40, '0, 1'b1, 32'h1234_5678, 1);
    wait_idle();
    chk_cnt(32'd3, 32'd1);

    // write miss does not allocate; following read misses
    issue(1'b1, 32'h80, 32'hAAAA_5555, 1'b1, '0, 2);
    wait_idle();
    chk_log("wr80", 1'b1, 32'h80, 32'hAAAA_5555);
    ret_dly = 0;
    issue(1'b0, 32'h80, '0, 1'b1, 32'hAAAA_5555, 3);
    wait_idle();
    chk_log("rd80", 1'b0, 32'h80, '0);
    chk_cnt(32'd3, 32'd3);

    // conflict on index 0
    ret_dly = 1;
    issue(1'b0, 32'h40, '0, 1'b1, 32'h1234_5678, 4);
    issue(1'b0, 32'h80, '0, 1'b1, 32'hAAAA_5555, 4);
    issue(1'b0, 32'h40, '0, 1'b1, 32'h1234_5678, 4);
    wait_idle();
    chk_log("conf_a", 1'b0, 32'h40, '0);
    chk_log("conf_b", 1'b0, 32'h80, '0);
    chk_log("conf_c", 1'b0, 32'h40, '0);
    chk_cnt(32'd3, 32'd6);

    // flush together with a request: flush wins
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op_type = 1'b0; req_addr = 32'h40;
    #1 chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("after_flush_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("flush_no_memreq", 32'(mem_log.size()), 32'd0);
    chk_cnt(32'd3, 32'd6);
    issue(1'b0, 32'h40, '0, 1'b1, 32'h1234_5678, 4);
    wait_idle();
    chk_log("post_flush", 1'b0, 32'h40, '0);
    chk_cnt(32'd3, 32'd7);

    // reset while waiting for refill data; the late return must be ignored
    ret_dly = 6;
    issue(1'b0, 32'h100, '0, 1'b0, '0, 0);
    begin
      int n = 0;
      while (mem_log.size() == 0 && n < 50) begin
        @(negedge clk); #1;
        n++;
      end
      chk("rdwait_reached", 32'(mem_log.size()), 32'd1);
    end
    void'(mem_log.pop_front());
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk_cnt(32'd0, 32'd0);
    repeat (8) @(negedge clk);
    chk("late_no_memreq", {31'd0, mem_req_valid}, 32'd0);
    chk_cnt(32'd0, 32'd0);
    ret_dly = 0;
    issue(1'b0, 32'h100, '0, 1'b1, 32'h0BAD_F00D, 3);
    wait_idle();
    chk_log("post_abort", 1'b0, 32'h100, '0);
    chk_cnt(32'd0, 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("memlog_drained", 32'(mem_log.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Controller for the core's direct-mapped data cache, sitting between the load/store stage and main memory.
- Accepts one CPU read or write at a time and performs tag lookup.
- Sequences refill on a read miss and write-through on every store.
- Owns the tag, valid and data arrays.
- Exposes hit/miss counters for performance debug.

Parameters:
CACHE_SIZE, 16, number of lines (one 32-bit word per line); power of two, at least 2
IDX_W, $clog2(CACHE_SIZE), index width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept a request
req_addr  in  32  byte address; bits [1:0] ignored
req_wdata  in  32  store data
op_type  in  1  0 = read, 1 = write
flush  in  1  invalidate all lines
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  load data, valid with resp_valid on reads
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned memory address
mem_we  out  1  1 = write, 0 = read
mem_wdata  out  32  memory write data
mem_resp_valid  in  1  read data returned
mem_rdata  in  32  memory read data
hit_count  out  32  lookups that hit, saturating
miss_count  out  32  lookups that missed, saturating

Behaviour:
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
- Reset (async):
  - state goes to IDLE and all valid bits clear.
  - All outputs go to 0, counters included. req_ready becomes 1 once rst deasserts.
  - Reset mid-refill or mid-write aborts the transaction and drops mem_req_valid immediately. No response is issued.
- States and transitions:
  - IDLE: req_ready = 1.
    - On req_valid && !flush, latch addr, wdata and op, then go to LOOKUP.
    - On flush, clear all valid bits and stay in IDLE. req_ready = 0 in that cycle, so flush wins over a simultaneous request.
  - LOOKUP (1 cycle): hit = valid[idx] && tag match. Increment hit_count or miss_count.
    - Read hit: resp_valid = 1, resp_rdata = line data, go to IDLE.
    - Read miss: go to RD_REQ.
    - Write (hit or miss): on a hit, update the line data in this cycle; on a miss, no allocate. Go to WR_REQ.
  - RD_REQ: mem_req_valid = 1, mem_we = 0, mem_addr = {addr[31:2], 2'b00}. Hold until mem_req_ready, then go to RD_WAIT.
  - RD_WAIT: wait for mem_resp_valid.
    - On that edge, write data, tag and valid to the line and register mem_rdata into resp_rdata.
    - Next cycle: resp_valid = 1, go to IDLE (RESP state, 1 cycle).
  - WR_REQ: mem_req_valid = 1, mem_we = 1, mem_wdata = latched wdata. Hold until mem_req_ready. In the following cycle resp_valid = 1, then go to IDLE. No memory response is expected for writes.
- Memory outputs stay stable while mem_req_valid = 1 && mem_req_ready = 0.
- mem_req_valid deasserts in the cycle after the handshake.
- Latency, counted from the accept edge:
  - Read hit: resp_valid in the next cycle (1 cycle).
  - Read miss: 3 + memory accept wait + memory return wait.
  - Write: 2 + memory accept wait.
- req_ready = 0 in every state except IDLE.
- flush is ignored outside IDLE.
- resp_rdata holds its last value between responses; it is don't-care on write responses.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- mem_resp_valid outside RD_WAIT is ignored.

Test Plan:
- Reset, then read 0x0000_0040 with memory returning 0xDEAD_BEEF after 2 cycles:
  - mem_req_valid=1, mem_we=0, mem_addr=0x40.
  - resp_valid with 0xDEAD_BEEF.
  - miss_count=1.
  - Re-reading 0x40 gives resp_valid exactly 1 cycle after accept, same data, hit_count=1, no memory request.
- Write 0x1234_5678 to 0x40 (resident) with mem_req_ready delayed 3 cycles:
  - mem_we=1 and mem_wdata held stable over the 3 wait cycles.
  - resp_valid fires once.
  - Re-reading 0x40 hits and returns 0x1234_5678.
- Write 0x0000_0080 (not resident), then read 0x80:
  - The write causes no allocate.
  - The read misses and issues mem_addr=0x80.
  - miss_count increments by 2 in total.
- Conflict, with CACHE_SIZE=16:
  - Read 0x40, then 0x80 (same index 0, different tag), then 0x40.
  - All three miss; 0x40 refetches from memory.
- Assert flush in IDLE together with req_valid:
  - req_ready=0 that cycle and the request is not accepted.
  - A subsequent read of a previously resident address misses.
- Assert rst while in RD_WAIT:
  - mem_req_valid=0, req_ready=1 after release, and no resp_valid.
  - A late mem_resp_valid is ignored.
  - Counters read 0.
